// File: rtl/vga_axil_slave.sv
// AXI4-lite slave front-end for the VGA top: one outstanding transaction, stretched write pulses.
// Optional macro VGA_AXIL_ADDR_CHECK_EN: out-of-range accesses are answered locally with SLVERR.
module vga_axil_slave #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 13,
  parameter int unsigned WR_PULSE         = 2,
  parameter int unsigned RD_LAT           = 3
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            s_awvalid_i,
  output logic                            s_awready_o,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     s_awaddr_i,
  input  logic                            s_wvalid_i,
  output logic                            s_wready_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]     s_wdata_i,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   s_wstrb_i,
  output logic                            s_bvalid_o,
  input  logic                            s_bready_i,
  output logic [1:0]                      s_bresp_o,
  input  logic                            s_arvalid_i,
  output logic                            s_arready_o,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     s_araddr_i,
  output logic                            s_rvalid_o,
  input  logic                            s_rready_i,
  output logic [C_AXI_DATA_WIDTH-1:0]     s_rdata_o,
  output logic [1:0]                      s_rresp_o,
  output logic                            axil_wready_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]     axil_waddr_o,
  output logic [C_AXI_DATA_WIDTH-1:0]     axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   axil_wstrb_o,
  output logic                            axil_rreq_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]     axil_raddr_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]     axil_rdata_i
);

  localparam int unsigned MAX_CNT     = (WR_PULSE > RD_LAT) ? WR_PULSE : RD_LAT;
  localparam int unsigned CNT_W       = $clog2(MAX_CNT + 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WPULSE, BRESP, RREQ, RRESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_wr;
  logic             wr_elig;
  logic             rd_elig;
  logic             grant_wr;
  logic             grant_rd;
  logic             wr_ok;
  logic             rd_ok;

`ifdef VGA_AXIL_ADDR_CHECK_EN
  localparam int unsigned FONT_LIMIT = 2048;
  localparam int unsigned BUF_LIMIT  = 6496;

  // Font ROM lives below 2 KiB, char buffer spans 0x1000 up to BUF_LIMIT.
  function automatic logic addr_legal(input logic [C_AXI_ADDR_WIDTH-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return a[12] ? (a32 < BUF_LIMIT) : (a32 < FONT_LIMIT);
  endfunction

  assign wr_ok = addr_legal(s_awaddr_i);
  assign rd_ok = addr_legal(s_araddr_i);
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  // Acceptance and round-robin arbitration; held off while reset is asserted.
  always_comb begin
    wr_elig  = rstn_i && (state == IDLE) && s_awvalid_i && s_wvalid_i;
    rd_elig  = rstn_i && (state == IDLE) && s_arvalid_i;
    grant_wr = wr_elig && (!rd_elig || !last_wr);
    grant_rd = rd_elig && !grant_wr;
  end

  assign s_awready_o = grant_wr;
  assign s_wready_o  = grant_wr;
  assign s_arready_o = grant_rd;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      cnt           <= '0;
      last_wr       <= 1'b0;
      s_bvalid_o    <= 1'b0;
      s_bresp_o     <= RESP_OKAY;
      s_rvalid_o    <= 1'b0;
      s_rdata_o     <= '0;
      s_rresp_o     <= RESP_OKAY;
      axil_wready_o <= 1'b0;
      axil_waddr_o  <= '0;
      axil_wdata_o  <= '0;
      axil_wstrb_o  <= '0;
      axil_rreq_o   <= 1'b0;
      axil_raddr_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            last_wr      <= 1'b1;
            axil_waddr_o <= s_awaddr_i;
            axil_wdata_o <= s_wdata_i;
            axil_wstrb_o <= s_wstrb_i;
            if (wr_ok) begin
              axil_wready_o <= 1'b1;
              cnt           <= CNT_W'(WR_PULSE - 1);
              state         <= WPULSE;
            end else begin
              s_bvalid_o <= 1'b1;
              s_bresp_o  <= RESP_SLVERR;
              state      <= BRESP;
            end
          end else if (grant_rd) begin
            last_wr      <= 1'b0;
            axil_raddr_o <= s_araddr_i;
            if (rd_ok) begin
              axil_rreq_o <= 1'b1;
              cnt         <= CNT_W'(RD_LAT - 1);
              state       <= RREQ;
            end else begin
              s_rvalid_o <= 1'b1;
              s_rdata_o  <= '0;
              s_rresp_o  <= RESP_SLVERR;
              state      <= RRESP;
            end
          end
        end
        WPULSE: begin
          if (cnt == '0) begin
            axil_wready_o <= 1'b0;
            s_bvalid_o    <= 1'b1;
            s_bresp_o     <= RESP_OKAY;
            state         <= BRESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        BRESP: begin
          if (s_bready_i) begin
            s_bvalid_o <= 1'b0;
            state      <= IDLE;
          end
        end
        RREQ: begin
          // Last request cycle: the sink's data is valid now.
          if (cnt == '0) begin
            axil_rreq_o <= 1'b0;
            s_rdata_o   <= axil_rdata_i;
            s_rresp_o   <= RESP_OKAY;
            s_rvalid_o  <= 1'b1;
            state       <= RRESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RRESP: begin
          if (s_rready_i) begin
            s_rvalid_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_axil_slave.sv
// Self-checking bench for vga_axil_slave: directed scenarios plus random transactions
// checked cycle-by-cycle against a transaction-level timing/response model.
module tb_vga_axil_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 13;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned WR_PULSE = 2;
  localparam int unsigned RD_LAT = 3;
`ifdef VGA_AXIL_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          s_awvalid_i = 1'b0, s_awready_o;
  logic [AW-1:0] s_awaddr_i = '0;
  logic          s_wvalid_i = 1'b0, s_wready_o;
  logic [DW-1:0] s_wdata_i = '0;
  logic [SW-1:0] s_wstrb_i = '0;
  logic          s_bvalid_o, s_bready_i = 1'b0;
  logic [1:0]    s_bresp_o;
  logic          s_arvalid_i = 1'b0, s_arready_o;
  logic [AW-1:0] s_araddr_i = '0;
  logic          s_rvalid_o, s_rready_i = 1'b0;
  logic [DW-1:0] s_rdata_o;
  logic [1:0]    s_rresp_o;
  logic          axil_wready_o;
  logic [AW-1:0] axil_waddr_o;
  logic [DW-1:0] axil_wdata_o;
  logic [SW-1:0] axil_wstrb_o;
  logic          axil_rreq_o;
  logic [AW-1:0] axil_raddr_o;
  logic [DW-1:0] axil_rdata_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit            m_last_wr = 1'b0;
  logic [AW-1:0] m_waddr = '0, p_waddr = '0;
  logic [DW-1:0] m_wdata = '0, p_wdata = '0;
  logic [SW-1:0] m_wstrb = '0, p_wstrb = '0;
  logic [AW-1:0] m_raddr = '0, p_raddr = '0;

  always #5 clk_i = ~clk_i;

  vga_axil_slave #(
    .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .WR_PULSE(WR_PULSE), .RD_LAT(RD_LAT)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
    .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
    .axil_wready_o(axil_wready_o), .axil_waddr_o(axil_waddr_o), .axil_wdata_o(axil_wdata_o),
    .axil_wstrb_o(axil_wstrb_o), .axil_rreq_o(axil_rreq_o), .axil_raddr_o(axil_raddr_o),
    .axil_rdata_i(axil_rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [AW-1:0] a);
    int unsigned v;
    v = 32'(a);
    return !CHECK_EN || (v < 2048) || (v >= 4096 && v < 6496);
  endfunction

  task automatic model_reset();
    m_last_wr = 1'b0;
    m_waddr = '0; m_wdata = '0; m_wstrb = '0; m_raddr = '0;
  endtask

  task automatic start_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    p_waddr = a; p_wdata = d; p_wstrb = s;
    s_awaddr_i = a; s_wdata_i = d; s_wstrb_i = s;
    s_awvalid_i = 1'b1; s_wvalid_i = 1'b1;
  endtask

  task automatic start_rd(input logic [AW-1:0] a);
    p_raddr = a; s_araddr_i = a; s_arvalid_i = 1'b1;
  endtask

  // Called in the low phase of an IDLE cycle with AW/W valid; runs through the B handshake.
  task automatic wr_body(input int stall);
    bit ok;
    int bstart;
    ok = legal(p_waddr);
    check("wr_accept", {s_awready_o, s_wready_o}, 2'b11);
    @(posedge clk_i); @(negedge clk_i);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    m_last_wr = 1'b1;
    m_waddr = p_waddr; m_wdata = p_wdata; m_wstrb = p_wstrb;
    bstart = ok ? WR_PULSE + 1 : 1;
    for (int k = 1; k <= bstart + stall; k++) begin
      if (k == bstart + stall) s_bready_i = 1'b1;
      #1;
      // {axil_wready, bvalid, rreq, rvalid, awready, arready}
      check("wr_ctl", {axil_wready_o, s_bvalid_o, axil_rreq_o, s_rvalid_o, s_awready_o, s_arready_o},
            {ok && (k <= WR_PULSE), k >= bstart, 1'b0, 1'b0, 1'b0, 1'b0});
      check("wr_fields", {axil_waddr_o, axil_wdata_o, axil_wstrb_o}, {m_waddr, m_wdata, m_wstrb});
      if (k >= bstart) check("bresp", s_bresp_o, ok ? 2'b00 : 2'b10);
      if (k < bstart + stall) @(negedge clk_i);
    end
    @(posedge clk_i); @(negedge clk_i);
    s_bready_i = 1'b0;
    #1;
    check("b_done", s_bvalid_o, 1'b0);
  endtask

  // Called in the low phase of an IDLE cycle with AR valid; runs through the R handshake.
  task automatic rd_body(input int stall, input logic [DW-1:0] data);
    bit ok;
    int rstart;
    logic [DW-1:0] exp_d;
    ok = legal(p_raddr);
    check("rd_accept", s_arready_o, 1'b1);
    @(posedge clk_i); @(negedge clk_i);
    s_arvalid_i = 1'b0;
    m_last_wr = 1'b0;
    m_raddr = p_raddr;
    rstart = ok ? RD_LAT + 1 : 1;
    exp_d = ok ? data : '0;
    for (int k = 1; k <= rstart + stall; k++) begin
      axil_rdata_i = (k == RD_LAT) ? data : $urandom;
      if (k == rstart + stall) s_rready_i = 1'b1;
      #1;
      check("rd_ctl", {axil_wready_o, s_bvalid_o, axil_rreq_o, s_rvalid_o, s_awready_o, s_arready_o},
            {1'b0, 1'b0, ok && (k <= RD_LAT), k >= rstart, 1'b0, 1'b0});
      check("raddr", axil_raddr_o, m_raddr);
      check("wfields_hold", {axil_waddr_o, axil_wdata_o, axil_wstrb_o}, {m_waddr, m_wdata, m_wstrb});
      if (k >= rstart) check("rdata", {s_rresp_o, s_rdata_o}, {ok ? 2'b00 : 2'b10, exp_d});
      if (k < rstart + stall) @(negedge clk_i);
    end
    @(posedge clk_i); @(negedge clk_i);
    s_rready_i = 1'b0;
    #1;
    check("r_done", s_rvalid_o, 1'b0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input int stall);
    start_wr(a, d, s);
    #1;
    wr_body(stall);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall);
    start_rd(a);
    #1;
    rd_body(stall, d);
  endtask

  // Both requests valid together: the type not granted last goes first.
  task automatic do_both(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                         input logic [AW-1:0] ra, input logic [DW-1:0] rd, input int wst, input int rst);
    start_wr(wa, wd, ws);
    start_rd(ra);
    #1;
    check("arb", {s_awready_o, s_arready_o}, m_last_wr ? 2'b01 : 2'b10);
    if (m_last_wr) begin
      rd_body(rst, rd);
      wr_body(wst);
    end else begin
      wr_body(wst);
      rd_body(rst, rd);
    end
  endtask

  initial begin
    // T1: reset with all requests pending
    start_wr(13'h0010, 32'hDEADBEEF, 4'hA);
    start_rd(13'h1010);
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_ctl", {s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o, axil_wready_o,
                      axil_rreq_o}, 7'b0);
    check("rst_fields", {axil_waddr_o, axil_wdata_o, axil_wstrb_o}, 49'b0);
    check("rst_resp", {axil_raddr_o, s_rdata_o, s_rresp_o, s_bresp_o}, 49'b0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    check("rst_arb", {s_awready_o, s_wready_o, s_arready_o}, 3'b110);
    wr_body(0);
    rd_body(1, 32'h5A5A0001);

    // T2: font/char write with long B stall
    do_write(13'h1004, 32'h41424344, 4'hF, 10);
    // T4: simultaneous after a write -> read first
    do_both(13'h0020, 32'h11223344, 4'h3, 13'h0024, 32'hCAFEF00D, 2, 0);
    do_both(13'h1100, 32'h99887766, 4'hC, 13'h1104, 32'h01020304, 0, 3);
    // T3: read with R stall
    do_read(13'h1008, 32'h31323334, 5);
    // T5 and range boundaries
    do_write(13'h1960, 32'h0BADF00D, 4'hF, 1);
    do_read(13'h0900, 32'h77777777, 1);
    do_write(13'h195F, 32'h12345678, 4'h1, 0);
    do_read(13'h07FF, 32'h87654321, 0);
    do_read(13'h0800, 32'h55AA55AA, 2);
    do_both(13'h1FFF, 32'h13579BDF, 4'h6, 13'h1000, 32'h2468ACE0, 0, 0);

    // Random transactions
    for (int i = 0; i < 30; i++) begin
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd, rd;
      logic [SW-1:0] ws;
      int op;
      wa = AW'($urandom_range(0, 8191));
      ra = AW'($urandom_range(0, 8191));
      wd = $urandom; rd = $urandom; ws = SW'($urandom);
      op = $urandom_range(0, 2);
      if (op == 0) do_write(wa, wd, ws, $urandom_range(0, 4));
      else if (op == 1) do_read(ra, rd, $urandom_range(0, 4));
      else do_both(wa, wd, ws, ra, rd, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // T6: reset during the write pulse aborts the transaction
    start_wr(13'h0004, 32'hF00DCAFE, 4'h3);
    #1;
    @(posedge clk_i); @(negedge clk_i);
    s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
    #1;
    check("t6_pulse", axil_wready_o, 1'b1);
    #1 rstn_i = 1'b0;
    #1;
    check("t6_abort", {axil_wready_o, s_bvalid_o, axil_waddr_o}, 15'b0);
    model_reset();
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t6_noresp", {s_bvalid_o, axil_wready_o, s_rvalid_o, axil_rreq_o}, 4'b0);
      @(negedge clk_i);
    end
    #1;
    do_both(13'h1234, 32'hA1B2C3D4, 4'h9, 13'h0042, 32'h0F0F0F0F, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
